// File: rtl/counter_regs_pkg.sv
// Shared register map and sequencer state encoding for the counter block.
// Optional feature macro: COUNTER_SEQ_AUTO_OVF_CLR_EN adds the OVF_CLR state.
package counter_regs_pkg;

  localparam int unsigned REG_ADDR_W = 10;

  // Register addresses
  localparam logic [REG_ADDR_W-1:0] CR_ADDR = 10'h000;
  localparam logic [REG_ADDR_W-1:0] SR_ADDR = 10'h004;

  // CR bit positions
  localparam int unsigned CR_CNT = 0;
  localparam int unsigned CR_CLR = 1;

  // SR fields
  localparam int unsigned SR_CNT_LSB = 0;
  localparam int unsigned SR_CNT_MSB = 2;
  localparam int unsigned SR_OVF     = 3;
  localparam int unsigned SR_W       = 4;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLR,
    S_UNCLR,
    S_PULSE,
    S_PULSE_LO,
    S_GAP,
    S_READ,
    S_CAPTURE,
`ifdef COUNTER_SEQ_AUTO_OVF_CLR_EN
    S_OVF_CLR,
`endif
    S_DONE
  } seq_state_e;

endpackage

// File: rtl/counter_bus_drv.sv
// Registered register-port driver: turns a one-hot write/read request into
// single-cycle m_* strobes, forcing address and data to zero when idle.
// Ports: clk, rst (sync, active-high); req_wr/req_rd/req_addr/req_data in;
//        m_wr_en/m_rd_en/m_addr/m_wdata out (all registered).
module counter_bus_drv #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_wr,
  input  logic              req_rd,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              m_wr_en,
  output logic              m_rd_en,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata
);

  logic              wr_en_d, wr_en_q;
  logic              rd_en_d, rd_en_q;
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic [DATA_W-1:0] wdata_d, wdata_q;

  // Write wins if both are requested so the strobes can never overlap
  always_comb begin
    wr_en_d = req_wr;
    rd_en_d = req_rd & ~req_wr;
    addr_d  = (wr_en_d | rd_en_d) ? req_addr : '0;
    wdata_d = wr_en_d ? req_data : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_q <= 1'b0;
      rd_en_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      wr_en_q <= wr_en_d;
      rd_en_q <= rd_en_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign m_wr_en = wr_en_q;
  assign m_rd_en = rd_en_q;
  assign m_addr  = addr_q;
  assign m_wdata = wdata_q;

endmodule

// File: rtl/counter_seq_ctrl.sv
// Bus-master sequencer for the counter block: optional clear, N count pulses
// with a programmable idle gap after each, then an SR read-back.
// Optional feature macro: COUNTER_SEQ_AUTO_OVF_CLR_EN (clear sticky overflow
// with an SR=0 write after a read-back that shows it set).
// Ports: clk, rst (sync, active-high); command start/clr_first/num_pulses/gap;
//        status busy/done/status/ovf_seen; counter port m_wr_en/m_rd_en/
//        m_addr/m_wdata out, m_rdata/m_overflow in. All outputs registered.
module counter_seq_ctrl #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned GAP_W  = 4,
  parameter logic [ADDR_W-1:0] CR_ADDR = ADDR_W'(counter_regs_pkg::CR_ADDR),
  parameter logic [ADDR_W-1:0] SR_ADDR = ADDR_W'(counter_regs_pkg::SR_ADDR)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              clr_first,
  input  logic [CNT_W-1:0]  num_pulses,
  input  logic [GAP_W-1:0]  gap,
  output logic              busy,
  output logic              done,
  output logic [3:0]        status,
  output logic              ovf_seen,
  output logic              m_wr_en,
  output logic              m_rd_en,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_overflow
);

  import counter_regs_pkg::*;

  localparam logic [DATA_W-1:0] CR_V_CNT = DATA_W'(1) << CR_CNT;
  localparam logic [DATA_W-1:0] CR_V_CLR = DATA_W'(1) << CR_CLR;

  seq_state_e        state_d, state_q;
  logic [CNT_W-1:0]  rem_d, rem_q;
  logic [GAP_W-1:0]  gap_d, gap_q;
  logic [GAP_W-1:0]  gcnt_d, gcnt_q;
  logic [SR_W-1:0]   status_d, status_q;
  logic              ovf_d, ovf_q;
  logic              busy_d, busy_q;
  logic              done_d, done_q;

  logic              req_wr, req_rd;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;

  logic              unused_rdata;
  assign unused_rdata = ^m_rdata[DATA_W-1:SR_W];

  // Next state, command latches and the bus op for the state being entered,
  // so the registered strobe lines up with the state that owns it
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    gap_d    = gap_q;
    gcnt_d   = gcnt_q;
    status_d = status_q;
    ovf_d    = ovf_q;
    req_wr   = 1'b0;
    req_rd   = 1'b0;
    req_addr = '0;
    req_data = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          rem_d = num_pulses;
          gap_d = gap;
          ovf_d = 1'b0;
          if (clr_first)            state_d = S_CLR;
          else if (num_pulses != '0) state_d = S_PULSE;
          else                       state_d = S_READ;
        end
      end
      S_CLR:   state_d = S_UNCLR;
      S_UNCLR: state_d = (rem_q != '0) ? S_PULSE : S_READ;
      S_PULSE: begin
        rem_d   = rem_q - CNT_W'(1);
        state_d = S_PULSE_LO;
      end
      S_PULSE_LO: begin
        if (gap_q != '0) begin
          gcnt_d  = gap_q - GAP_W'(1);
          state_d = S_GAP;
        end else begin
          state_d = (rem_q != '0) ? S_PULSE : S_READ;
        end
      end
      S_GAP: begin
        if (gcnt_q == '0) state_d = (rem_q != '0) ? S_PULSE : S_READ;
        else              gcnt_d  = gcnt_q - GAP_W'(1);
      end
      S_READ:  state_d = S_CAPTURE;
      S_CAPTURE: begin
        status_d = m_rdata[SR_W-1:0];
`ifdef COUNTER_SEQ_AUTO_OVF_CLR_EN
        state_d  = m_rdata[SR_OVF] ? S_OVF_CLR : S_DONE;
`else
        state_d  = S_DONE;
`endif
      end
`ifdef COUNTER_SEQ_AUTO_OVF_CLR_EN
      S_OVF_CLR: state_d = S_DONE;
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Overflow observation window: first bus op through CAPTURE
    if (state_q inside {S_CLR, S_UNCLR, S_PULSE, S_PULSE_LO, S_GAP, S_READ,
                        S_CAPTURE}) begin
      ovf_d = ovf_q | m_overflow;
    end

    case (state_d)
      S_CLR:      begin req_wr = 1'b1; req_addr = CR_ADDR; req_data = CR_V_CLR; end
      S_UNCLR:    begin req_wr = 1'b1; req_addr = CR_ADDR; end
      S_PULSE:    begin req_wr = 1'b1; req_addr = CR_ADDR; req_data = CR_V_CNT; end
      S_PULSE_LO: begin req_wr = 1'b1; req_addr = CR_ADDR; end
      S_READ:     begin req_rd = 1'b1; req_addr = SR_ADDR; end
`ifdef COUNTER_SEQ_AUTO_OVF_CLR_EN
      S_OVF_CLR:  begin req_wr = 1'b1; req_addr = SR_ADDR; end
`endif
      default: ;
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rem_q    <= '0;
      gap_q    <= '0;
      gcnt_q   <= '0;
      status_q <= '0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      gap_q    <= gap_d;
      gcnt_q   <= gcnt_d;
      status_q <= status_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  counter_bus_drv #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_bus_drv (
    .clk      (clk),
    .rst      (rst),
    .req_wr   (req_wr),
    .req_rd   (req_rd),
    .req_addr (req_addr),
    .req_data (req_data),
    .m_wr_en  (m_wr_en),
    .m_rd_en  (m_rd_en),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata)
  );

  assign busy     = busy_q;
  assign done     = done_q;
  assign status   = status_q;
  assign ovf_seen = ovf_q;

endmodule
